// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction per ack cycle; per-requester completed-grant counters.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_data_out,

    output logic [CW-1:0] gnt_cnt_a,
    output logic [CW-1:0] gnt_cnt_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic          LAST_A  = 1'b0;
    localparam logic          LAST_B  = 1'b1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_next;
    logic          r_last;
    logic [CW-1:0] r_gnt_cnt_a;
    logic [CW-1:0] r_gnt_cnt_b;

    // Arbitration is the same from every state, so an ack cycle can be
    // followed directly by another grant without an idle bubble.
    always_comb begin
        w_state_next = IDLE;
        if (a_req && b_req) begin
            w_state_next = (r_last == LAST_A) ? GNT_B : GNT_A;
        end else if (a_req) begin
            w_state_next = GNT_A;
        end else if (b_req) begin
            w_state_next = GNT_B;
        end
    end

    // Counters advance on the edge that closes a grant cycle, so an async
    // reset inside that cycle clears them before the increment can land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= LAST_B;
            r_gnt_cnt_a <= '0;
            r_gnt_cnt_b <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == GNT_A) begin
                r_last <= LAST_A;
            end else if (w_state_next == GNT_B) begin
                r_last <= LAST_B;
            end
            if (r_state == GNT_A) begin
                r_gnt_cnt_a <= r_gnt_cnt_a + CNT_ONE;
            end
            if (r_state == GNT_B) begin
                r_gnt_cnt_b <= r_gnt_cnt_b + CNT_ONE;
            end
        end
    end

    // Memory-side and requester-side outputs depend only on the registered
    // state plus the granted requester's inputs.
    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_WE      = 1'b0;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        a_rdata     = '0;
        b_rdata     = '0;
        case (r_state)
            GNT_A: begin
                mem_address = a_addr;
                mem_data_in = a_wdata;
                mem_WE      = a_we;
                a_ack       = 1'b1;
                a_rdata     = mem_data_out;
            end
            GNT_B: begin
                mem_address = b_addr;
                mem_data_in = b_wdata;
                mem_WE      = b_we;
                b_ack       = 1'b1;
                b_rdata     = mem_data_out;
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

    assign gnt_cnt_a = r_gnt_cnt_a;
    assign gnt_cnt_b = r_gnt_cnt_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_WE;
    logic [DW-1:0] mem_data_out;
    logic [CW-1:0] gnt_cnt_a, gnt_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_WE(mem_WE),
        .mem_data_out(mem_data_out),
        .gnt_cnt_a(gnt_cnt_a), .gnt_cnt_b(gnt_cnt_b)
    );

    // Data memory: combinational read, write on the falling edge.
    logic [DW-1:0] bmem [0:255];
    logic          mem_clr;
    assign mem_data_out = bmem[mem_address[9:2]];
    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) bmem[i] <= '0;
        end else if (mem_WE) begin
            bmem[mem_address[9:2]] <= mem_data_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic at_check();
        @(posedge clk); #1;
    endtask

    task automatic at_drive();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 0;
        idle_inputs();
        @(negedge clk); #1;
        rst_n = 1;
    endtask

    typedef struct {
        logic          a_req, a_we;
        logic [31:0]   a_addr, a_wdata;
        logic          b_req, b_we;
        logic [31:0]   b_addr, b_wdata;
        logic          e_a_ack, e_b_ack, e_we;
        logic [31:0]   e_addr, e_a_rdata, e_b_rdata;
    } vec_t;

    vec_t tbl [0:10];

    // Reference model state for the random run.
    logic [DW-1:0] shadow [0:255];
    bit            m_last_b;
    int            m_cnt_a, m_cnt_b;

    initial begin
        int g;
        logic [31:0] e_addr, e_wd, e_ard, e_brd;
        logic        e_we;

        mem_clr = 1;
        rst_n   = 0;
        idle_inputs();
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        // Reset: outputs stay quiet even with an active write request.
        a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            at_check();
            chk($sformatf("rst_mem_we[%0d]", k), mem_WE, 0);
            chk($sformatf("rst_a_ack[%0d]", k), a_ack, 0);
            chk($sformatf("rst_addr[%0d]", k), mem_address, 0);
            chk($sformatf("rst_cnt_a[%0d]", k), gnt_cnt_a, 0);
            chk($sformatf("rst_cnt_b[%0d]", k), gnt_cnt_b, 0);
        end
        at_drive();
        mem_clr = 0;
        idle_inputs();
        rst_n = 1;
        $display("reset released");

        // Single write from A.
        a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
        at_check();
        chk("wr_a_ack", a_ack, 1);
        chk("wr_mem_we", mem_WE, 1);
        chk("wr_mem_addr", mem_address, 32'h10);
        chk("wr_mem_data", mem_data_in, 32'hDEAD_BEEF);
        at_drive();
        a_req = 0; a_we = 0;
        at_check();
        chk("wr_a_ack_end", a_ack, 0);
        chk("wr_cnt_a", gnt_cnt_a, 1);
        chk("wr_mem_word4", bmem[4], 32'hDEAD_BEEF);
        $display("txn: A write 0x10 <= 0xdeadbeef");

        // Read-back from B.
        at_drive();
        b_req = 1; b_we = 0; b_addr = 32'h10;
        at_check();
        chk("rd_b_ack", b_ack, 1);
        chk("rd_b_rdata", b_rdata, 32'hDEAD_BEEF);
        chk("rd_a_rdata", a_rdata, 0);
        chk("rd_mem_we", mem_WE, 0);
        at_drive();
        b_req = 0;
        at_check();
        chk("rd_b_ack_end", b_ack, 0);
        chk("rd_cnt_b", gnt_cnt_b, 1);
        $display("txn: B read 0x10 -> 0x%0h", b_rdata);

        // Vector table, starting from reset (both requesting -> A first).
        //           areq awe aaddr  awdata        breq bwe baddr  bwdata        ea eb we addr   ardata        brdata
        tbl[0]  = '{1, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 1, 0, 1, 32'h20, 32'h0,         32'h0};
        tbl[1]  = '{1, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 0, 1, 1, 32'h24, 32'h0,         32'h0};
        tbl[2]  = '{1, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 1, 0, 1, 32'h20, 32'h1111_1111, 32'h0};
        tbl[3]  = '{0, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 0, 1, 1, 32'h24, 32'h0,         32'h2222_2222};
        tbl[4]  = '{0, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 0, 1, 1, 32'h24, 32'h0,         32'h2222_2222};
        tbl[5]  = '{1, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222, 1, 0, 1, 32'h20, 32'h1111_1111, 32'h0};
        tbl[6]  = '{0, 0, 32'h20, 32'h0,         0, 0, 32'h24, 32'h0,         0, 0, 0, 32'h0,  32'h0,         32'h0};
        tbl[7]  = '{1, 0, 32'h24, 32'h0,         0, 0, 32'h24, 32'h0,         1, 0, 0, 32'h24, 32'h2222_2222, 32'h0};
        tbl[8]  = '{1, 0, 32'h20, 32'h0,         0, 0, 32'h24, 32'h0,         1, 0, 0, 32'h20, 32'h1111_1111, 32'h0};
        tbl[9]  = '{1, 0, 32'h20, 32'h0,         1, 0, 32'h20, 32'h0,         0, 1, 0, 32'h20, 32'h0,         32'h1111_1111};
        tbl[10] = '{0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,         0, 0, 0, 32'h0,  32'h0,         32'h0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
            b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
            at_check();
            chk($sformatf("tbl[%0d].a_ack", i), a_ack, tbl[i].e_a_ack);
            chk($sformatf("tbl[%0d].b_ack", i), b_ack, tbl[i].e_b_ack);
            chk($sformatf("tbl[%0d].mem_we", i), mem_WE, tbl[i].e_we);
            chk($sformatf("tbl[%0d].mem_addr", i), mem_address, tbl[i].e_addr);
            chk($sformatf("tbl[%0d].a_rdata", i), a_rdata, tbl[i].e_a_rdata);
            chk($sformatf("tbl[%0d].b_rdata", i), b_rdata, tbl[i].e_b_rdata);
            $display("vec %0d: a_ack=%0b b_ack=%0b addr=0x%0h we=%0b", i, a_ack, b_ack, mem_address, mem_WE);
            at_drive();
        end
        chk("tbl_cnt_a", gnt_cnt_a, 5);
        chk("tbl_cnt_b", gnt_cnt_b, 4);

        // Contention: both held for six cycles -> A,B,A,B,A,B.
        do_reset();
        a_req = 1; a_addr = 32'h20; b_req = 1; b_addr = 32'h24;
        for (int k = 0; k < 6; k++) begin
            at_check();
            chk($sformatf("cont_a_ack[%0d]", k), a_ack, (k % 2 == 0));
            chk($sformatf("cont_b_ack[%0d]", k), b_ack, (k % 2 == 1));
            $display("contention cycle %0d: a_ack=%0b b_ack=%0b", k, a_ack, b_ack);
        end
        at_drive();
        idle_inputs();
        at_check();
        chk("cont_cnt_a", gnt_cnt_a, 3);
        chk("cont_cnt_b", gnt_cnt_b, 3);

        // Reset in the first half of a B write cycle cancels it.
        at_drive();
        a_req = 1; a_we = 1; a_addr = 32'h40; a_wdata = 32'hCAFE_F00D;
        at_check();
        at_drive();
        idle_inputs();
        b_req = 1; b_we = 1; b_addr = 32'h40; b_wdata = 32'h1234_5678;
        at_check();
        chk("mid_b_ack", b_ack, 1);
        chk("mid_pre_word", bmem[16], 32'hCAFE_F00D);
        #1 rst_n = 0;
        #1;
        chk("mid_a_ack", a_ack, 0);
        chk("mid_b_ack_rst", b_ack, 0);
        chk("mid_mem_we", mem_WE, 0);
        chk("mid_mem_addr", mem_address, 0);
        chk("mid_mem_data", mem_data_in, 0);
        chk("mid_b_rdata", b_rdata, 0);
        chk("mid_cnt_a", gnt_cnt_a, 0);
        chk("mid_cnt_b", gnt_cnt_b, 0);
        at_drive();
        chk("mid_word_kept", bmem[16], 32'hCAFE_F00D);
        idle_inputs();
        rst_n = 1;
        $display("txn: B write 0x40 cancelled by reset");

        // Idle for ten cycles.
        for (int k = 0; k < 10; k++) begin
            at_check();
            chk($sformatf("idle_we[%0d]", k), mem_WE, 0);
            chk($sformatf("idle_addr[%0d]", k), mem_address, 0);
            chk($sformatf("idle_acks[%0d]", k), {a_ack, b_ack}, 0);
        end
        $display("idle: 10 cycles quiet");

        // Randomized traffic against the reference model (words 128..191).
        do_reset();
        m_last_b = 1; m_cnt_a = 0; m_cnt_b = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            at_check();
            if (a_req && b_req) g = m_last_b ? 1 : 2;
            else if (a_req)     g = 1;
            else if (b_req)     g = 2;
            else                g = 0;
            e_addr = (g == 1) ? a_addr : (g == 2) ? b_addr : 32'h0;
            e_wd   = (g == 1) ? a_wdata : (g == 2) ? b_wdata : 32'h0;
            e_we   = (g == 1) ? a_we : (g == 2) ? b_we : 1'b0;
            e_ard  = (g == 1) ? shadow[e_addr[9:2]] : 32'h0;
            e_brd  = (g == 2) ? shadow[e_addr[9:2]] : 32'h0;
            chk($sformatf("rnd[%0d].a_ack", cyc), a_ack, (g == 1));
            chk($sformatf("rnd[%0d].b_ack", cyc), b_ack, (g == 2));
            chk($sformatf("rnd[%0d].addr", cyc), mem_address, e_addr);
            chk($sformatf("rnd[%0d].we", cyc), mem_WE, e_we);
            chk($sformatf("rnd[%0d].wdata", cyc), mem_data_in, e_wd);
            chk($sformatf("rnd[%0d].a_rdata", cyc), a_rdata, e_ard);
            chk($sformatf("rnd[%0d].b_rdata", cyc), b_rdata, e_brd);
            chk($sformatf("rnd[%0d].cnt_a", cyc), gnt_cnt_a, m_cnt_a % 65536);
            chk($sformatf("rnd[%0d].cnt_b", cyc), gnt_cnt_b, m_cnt_b % 65536);
            if (g != 0) begin
                m_last_b = (g == 2);
                if (e_we) shadow[e_addr[9:2]] = e_wd;
                if (g == 1) m_cnt_a++; else m_cnt_b++;
                $display("rnd %0d: grant %s addr=0x%0h we=%0b", cyc, (g == 1) ? "A" : "B", e_addr, e_we);
            end
            at_drive();
            // A requester may only change its request once its ack cycle is over or while idle.
            if (g == 1 || !a_req) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = $urandom_range(0, 1); a_addr = $urandom_range(128, 191) << 2; a_wdata = $urandom;
            end
            if (g == 2 || !b_req) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = $urandom_range(0, 1); b_addr = $urandom_range(128, 191) << 2; b_wdata = $urandom;
            end
        end
        idle_inputs();

        // Counter wrap: 2^CW back-to-back A grants.
        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h200;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_cnt_before", gnt_cnt_a, 16'hFFFF);
        at_drive();
        a_req = 0;
        at_check();
        chk("wrap_cnt_after", gnt_cnt_a, 0);
        chk("wrap_a_ack", a_ack, 0);
        $display("wrap: gnt_cnt_a=0x%0h after 65536 grants", gnt_cnt_a);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
